// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM states,
// CSR file addresses and mcause encodings.
package csr_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DEFER = 3'd1,
    S_ENTER = 3'd2,
    S_VEC   = 3'd3,
    S_RET   = 3'd4
  } trap_state_e;

  localparam logic [2:0] CSR_MSTATUS = 3'd0;
  localparam logic [2:0] CSR_MIE     = 3'd2;
  localparam logic [2:0] CSR_MTVEC   = 3'd3;
  localparam logic [2:0] CSR_MCAUSE  = 3'd4;
  localparam logic [2:0] CSR_MEPC    = 3'd5;
  localparam logic [2:0] CSR_MIP     = 3'd6;

  localparam logic [31:0] MCAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] MCAUSE_MTI = 32'h8000_0007;

endpackage

// File: rtl/csr_int_prio.sv
// Pending-interrupt detector and priority encoder. Software interrupt wins
// over timer interrupt; cause is zero when nothing is pending.
module csr_int_prio
  import csr_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_mie_mstatus,
  input  logic                  i_msip_mip,
  input  logic                  i_mtip_mip,
  input  logic                  i_msie_mie,
  input  logic                  i_mtie_mie,
  output logic                  o_pending,
  output logic [DATA_WIDTH-1:0] o_cause
);

  // Select the highest-priority enabled interrupt and its mcause value.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    o_pending = 1'b0;
    o_cause   = '0;
    if (i_mie_mstatus && i_msip_mip && i_msie_mie) begin
      o_pending = 1'b1;
      o_cause   = DATA_WIDTH'(MCAUSE_MSI);
    end else if (i_mie_mstatus && i_mtip_mip && i_mtie_mie) begin
      o_pending = 1'b1;
      o_cause   = DATA_WIDTH'(MCAUSE_MTI);
    end
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Trap sequencer owning the CSR file's two write ports. Forwards CSR
// instruction traffic when idle; sequences interrupt entry (mepc/mcause save,
// mtvec redirect) and MRET return (mepc redirect).
// Build option: define CSR_TRAP_VECTORED_EN to honour vectored mtvec mode.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  i_instr_done,
  input  logic [DATA_WIDTH-1:0] i_next_pc,
  input  logic                  i_mret,
  input  logic                  i_csr_we,
  input  logic [ADDR_WIDTH-1:0] i_csr_addr,
  input  logic [DATA_WIDTH-1:0] i_csr_wdata,
  input  logic [ADDR_WIDTH-1:0] i_csr_raddr,
  input  logic                  i_mie_mstatus,
  input  logic                  i_mtip_mip,
  input  logic                  i_msip_mip,
  input  logic                  i_mtie_mie,
  input  logic                  i_msie_mie,
  input  logic [DATA_WIDTH-1:0] i_csr_rdata,
  input  logic                  i_redirect_ready,
  output logic                  o_we_1,
  output logic [ADDR_WIDTH-1:0] o_waddr_1,
  output logic [DATA_WIDTH-1:0] o_wdata_1,
  output logic                  o_we_2,
  output logic [ADDR_WIDTH-1:0] o_waddr_2,
  output logic [DATA_WIDTH-1:0] o_wdata_2,
  output logic [ADDR_WIDTH-1:0] o_raddr,
  output logic                  o_interrupt_jump,
  output logic                  o_mret_instr,
  output logic                  o_csr_stall,
  output logic                  o_redirect_valid,
  output logic [DATA_WIDTH-1:0] o_redirect_pc
);

  trap_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] cause_q, cause_d;
  logic                  ret_first_q, ret_first_d;

  logic                  irq_pending;
  logic [DATA_WIDTH-1:0] irq_cause;
  logic [DATA_WIDTH-1:0] vec_base;
  logic [DATA_WIDTH-1:0] vec_target;

  csr_int_prio #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_int_prio (
    .i_mie_mstatus (i_mie_mstatus),
    .i_msip_mip    (i_msip_mip),
    .i_mtip_mip    (i_mtip_mip),
    .i_msie_mie    (i_msie_mie),
    .i_mtie_mie    (i_mtie_mie),
    .o_pending     (irq_pending),
    .o_cause       (irq_cause)
  );

  // mtvec base with mode bits cleared; vectored mode adds 4*cause[3:0].
  assign vec_base = {i_csr_rdata[DATA_WIDTH-1:2], 2'b00};
`ifdef CSR_TRAP_VECTORED_EN
  assign vec_target = (i_csr_rdata[1:0] == 2'b01)
                    ? vec_base + DATA_WIDTH'({cause_q[3:0], 2'b00})
                    : vec_base;
`else
  assign vec_target = vec_base;
`endif

  // Next-state logic; PC and cause are captured only at the evaluation points.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cause_d     = cause_q;
    ret_first_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_mret) begin
          state_d     = S_RET;
          ret_first_d = 1'b1;
        end else if (i_instr_done && i_csr_we) begin
          // Let the CSR write land before deciding whether to trap.
          pc_d    = i_next_pc;
          state_d = S_DEFER;
        end else if (i_instr_done && irq_pending) begin
          pc_d    = i_next_pc;
          cause_d = irq_cause;
          state_d = S_ENTER;
        end
      end
      S_DEFER: begin
        if (irq_pending) begin
          cause_d = irq_cause;
          state_d = S_ENTER;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ENTER: state_d = S_VEC;
      S_VEC:   if (i_redirect_ready) state_d = S_IDLE;
      S_RET:   if (i_redirect_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and capture registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      cause_q     <= '0;
      ret_first_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      pc_q        <= pc_d;
      cause_q     <= cause_d;
      ret_first_q <= ret_first_d;
    end
  end

  // Output decode; gated by reset so nothing is written while arstn is low.
  always_comb begin
    o_we_1           = 1'b0;
    o_waddr_1        = '0;
    o_wdata_1        = '0;
    o_we_2           = 1'b0;
    o_waddr_2        = '0;
    o_wdata_2        = '0;
    o_raddr          = '0;
    o_interrupt_jump = 1'b0;
    o_mret_instr     = 1'b0;
    o_csr_stall      = 1'b0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    if (arstn) begin
      case (state_q)
        S_IDLE: begin
          o_we_1    = i_csr_we;
          o_waddr_1 = i_csr_addr;
          o_wdata_1 = i_csr_wdata;
          o_raddr   = i_csr_raddr;
        end
        S_DEFER: o_csr_stall = 1'b1;
        S_ENTER: begin
          o_csr_stall      = 1'b1;
          o_we_1           = 1'b1;
          o_waddr_1        = ADDR_WIDTH'(CSR_MEPC);
          o_wdata_1        = pc_q;
          o_we_2           = 1'b1;
          o_waddr_2        = ADDR_WIDTH'(CSR_MCAUSE);
          o_wdata_2        = cause_q;
          o_interrupt_jump = 1'b1;
          o_raddr          = ADDR_WIDTH'(CSR_MTVEC);
        end
        S_VEC: begin
          o_csr_stall      = 1'b1;
          o_raddr          = ADDR_WIDTH'(CSR_MTVEC);
          o_redirect_valid = 1'b1;
          o_redirect_pc    = vec_target;
        end
        S_RET: begin
          o_csr_stall      = 1'b1;
          o_mret_instr     = ret_first_q;
          o_raddr          = ADDR_WIDTH'(CSR_MEPC);
          o_redirect_valid = 1'b1;
          o_redirect_pc    = i_csr_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed testbench for csr_trap_ctrl. The bench plays the CSR file by
// driving status bits and read data by hand.
module tb_csr_trap_ctrl;

  localparam int DW = 32;
  localparam int AW = 3;

`ifdef CSR_TRAP_VECTORED_EN
  localparam logic [31:0] EXP_PRIO_PC = 32'h8000_000C;
`else
  localparam logic [31:0] EXP_PRIO_PC = 32'h8000_0000;
`endif

  logic          clk;
  logic          arstn;
  logic          i_instr_done;
  logic [DW-1:0] i_next_pc;
  logic          i_mret;
  logic          i_csr_we;
  logic [AW-1:0] i_csr_addr;
  logic [DW-1:0] i_csr_wdata;
  logic [AW-1:0] i_csr_raddr;
  logic          i_mie_mstatus, i_mtip_mip, i_msip_mip, i_mtie_mie, i_msie_mie;
  logic [DW-1:0] i_csr_rdata;
  logic          i_redirect_ready;
  logic          o_we_1, o_we_2;
  logic [AW-1:0] o_waddr_1, o_waddr_2, o_raddr;
  logic [DW-1:0] o_wdata_1, o_wdata_2, o_redirect_pc;
  logic          o_interrupt_jump, o_mret_instr, o_csr_stall, o_redirect_valid;

  int n_checks = 0;
  int n_fail   = 0;

  csr_trap_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .arstn            (arstn),
    .i_instr_done     (i_instr_done),
    .i_next_pc        (i_next_pc),
    .i_mret           (i_mret),
    .i_csr_we         (i_csr_we),
    .i_csr_addr       (i_csr_addr),
    .i_csr_wdata      (i_csr_wdata),
    .i_csr_raddr      (i_csr_raddr),
    .i_mie_mstatus    (i_mie_mstatus),
    .i_mtip_mip       (i_mtip_mip),
    .i_msip_mip       (i_msip_mip),
    .i_mtie_mie       (i_mtie_mie),
    .i_msie_mie       (i_msie_mie),
    .i_csr_rdata      (i_csr_rdata),
    .i_redirect_ready (i_redirect_ready),
    .o_we_1           (o_we_1),
    .o_waddr_1        (o_waddr_1),
    .o_wdata_1        (o_wdata_1),
    .o_we_2           (o_we_2),
    .o_waddr_2        (o_waddr_2),
    .o_wdata_2        (o_wdata_2),
    .o_raddr          (o_raddr),
    .o_interrupt_jump (o_interrupt_jump),
    .o_mret_instr     (o_mret_instr),
    .o_csr_stall      (o_csr_stall),
    .o_redirect_valid (o_redirect_valid),
    .o_redirect_pc    (o_redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bits(input logic mie, input logic msip, input logic msie,
                          input logic mtip, input logic mtie);
    i_mie_mstatus = mie;
    i_msip_mip    = msip;
    i_msie_mie    = msie;
    i_mtip_mip    = mtip;
    i_mtie_mie    = mtie;
  endtask

  initial begin
    arstn = 1'b0;
    i_instr_done = 1'b0; i_next_pc = '0; i_mret = 1'b0;
    i_csr_we = 1'b1; i_csr_addr = 3'd2; i_csr_wdata = 32'h5; i_csr_raddr = 3'd6;
    set_bits(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    i_csr_rdata = '0; i_redirect_ready = 1'b0;

    // Reset: every output low even with a CSR write presented.
    #1;
    check("rst_we_1", 32'(o_we_1), 32'd0);
    check("rst_wdata_1", o_wdata_1, 32'd0);
    check("rst_raddr", 32'(o_raddr), 32'd0);
    check("rst_stall", 32'(o_csr_stall), 32'd0);
    check("rst_redirect_valid", 32'(o_redirect_valid), 32'd0);
    tick(); tick();
    arstn = 1'b1;

    // IDLE forwarding of a CSR-instruction write and read.
    i_csr_wdata = 32'h88;
    #1;
    check("idle_we_1", 32'(o_we_1), 32'd1);
    check("idle_waddr_1", 32'(o_waddr_1), 32'd2);
    check("idle_wdata_1", o_wdata_1, 32'h88);
    check("idle_raddr", 32'(o_raddr), 32'd6);
    check("idle_we_2", 32'(o_we_2), 32'd0);
    check("idle_stall", 32'(o_csr_stall), 32'd0);
    tick();
    i_csr_we = 1'b0;

    // Timer interrupt entry at PC 0x100, mtvec 0x8000_0000.
    set_bits(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    i_instr_done = 1'b1; i_next_pc = 32'h100;
    #1;
    check("entry_boundary_stall", 32'(o_csr_stall), 32'd0);
    tick();
    i_instr_done = 1'b0; i_next_pc = 32'hdead;
    i_csr_rdata = 32'h8000_0000;
    #1;
    check("enter_we_1", 32'(o_we_1), 32'd1);
    check("enter_waddr_1", 32'(o_waddr_1), 32'd5);
    check("enter_mepc", o_wdata_1, 32'h100);
    check("enter_we_2", 32'(o_we_2), 32'd1);
    check("enter_waddr_2", 32'(o_waddr_2), 32'd4);
    check("enter_mcause", o_wdata_2, 32'h8000_0007);
    check("enter_jump", 32'(o_interrupt_jump), 32'd1);
    check("enter_raddr", 32'(o_raddr), 32'd3);
    check("enter_stall", 32'(o_csr_stall), 32'd1);
    check("enter_redirect_valid", 32'(o_redirect_valid), 32'd0);
    tick();
    i_redirect_ready = 1'b1;
    #1;
    check("vec_redirect_valid", 32'(o_redirect_valid), 32'd1);
    check("vec_redirect_pc", o_redirect_pc, 32'h8000_0000);
    check("vec_jump", 32'(o_interrupt_jump), 32'd0);
    check("vec_we_1", 32'(o_we_1), 32'd0);
    tick();
    i_redirect_ready = 1'b0;
    set_bits(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("vec_exit_valid", 32'(o_redirect_valid), 32'd0);
    check("vec_exit_stall", 32'(o_csr_stall), 32'd0);

    // Priority: software beats timer; vectored mtvec with backpressure.
    set_bits(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    i_instr_done = 1'b1; i_next_pc = 32'h204;
    tick();
    i_instr_done = 1'b0;
    i_csr_rdata = 32'h8000_0001;
    #1;
    check("prio_mcause", o_wdata_2, 32'h8000_0003);
    check("prio_mepc", o_wdata_1, 32'h204);
    tick();
    // Interrupt bits dropping during VEC must not matter.
    set_bits(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", 32'(o_redirect_valid), 32'd1);
      check("bp_pc", o_redirect_pc, EXP_PRIO_PC);
      check("bp_stall", 32'(o_csr_stall), 32'd1);
      tick();
    end
    i_redirect_ready = 1'b1;
    #1;
    check("bp_ready_pc", o_redirect_pc, EXP_PRIO_PC);
    tick();
    i_redirect_ready = 1'b0;
    #1;
    check("bp_exit_valid", 32'(o_redirect_valid), 32'd0);
    check("bp_exit_stall", 32'(o_csr_stall), 32'd0);

    // CSR write clearing mstatus.MIE alongside the boundary: no entry.
    set_bits(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    i_instr_done = 1'b1; i_next_pc = 32'h300;
    i_csr_we = 1'b1; i_csr_addr = 3'd0; i_csr_wdata = 32'h0;
    #1;
    check("coin_we_1", 32'(o_we_1), 32'd1);
    check("coin_waddr_1", 32'(o_waddr_1), 32'd0);
    check("coin_stall", 32'(o_csr_stall), 32'd0);
    tick();
    i_instr_done = 1'b0; i_csr_we = 1'b0;
    i_mie_mstatus = 1'b0;
    #1;
    check("defer_stall", 32'(o_csr_stall), 32'd1);
    check("defer_we_1", 32'(o_we_1), 32'd0);
    tick();
    #1;
    check("defer_idle_stall", 32'(o_csr_stall), 32'd0);
    check("defer_idle_we_2", 32'(o_we_2), 32'd0);
    check("defer_idle_jump", 32'(o_interrupt_jump), 32'd0);

    // CSR write leaving the interrupt pending: entry via DEFER, 3-cycle redirect.
    i_mie_mstatus = 1'b1;
    i_instr_done = 1'b1; i_next_pc = 32'h340;
    i_csr_we = 1'b1; i_csr_addr = 3'd2; i_csr_wdata = 32'h80;
    tick();
    i_instr_done = 1'b0;
    #1;
    check("defer2_stall", 32'(o_csr_stall), 32'd1);
    check("defer2_blocks_we", 32'(o_we_1), 32'd0);
    tick();
    i_csr_we = 1'b0;
    i_csr_rdata = 32'h0000_1000;
    #1;
    check("defer2_mepc", o_wdata_1, 32'h340);
    check("defer2_mcause", o_wdata_2, 32'h8000_0007);
    tick();
    i_redirect_ready = 1'b1;
    #1;
    check("defer2_redirect_pc", o_redirect_pc, 32'h0000_1000);
    tick();
    i_redirect_ready = 1'b0;

    // MRET with an interrupt still pending: MRET wins.
    i_mret = 1'b1; i_instr_done = 1'b1; i_next_pc = 32'h400;
    tick();
    i_mret = 1'b0; i_instr_done = 1'b0;
    i_csr_rdata = 32'h200;
    #1;
    check("ret_mret_instr", 32'(o_mret_instr), 32'd1);
    check("ret_raddr", 32'(o_raddr), 32'd5);
    check("ret_valid", 32'(o_redirect_valid), 32'd1);
    check("ret_pc", o_redirect_pc, 32'h200);
    check("ret_jump", 32'(o_interrupt_jump), 32'd0);
    check("ret_we_2", 32'(o_we_2), 32'd0);
    tick();
    i_redirect_ready = 1'b1;
    #1;
    check("ret2_mret_instr", 32'(o_mret_instr), 32'd0);
    check("ret2_pc", o_redirect_pc, 32'h200);
    check("ret2_stall", 32'(o_csr_stall), 32'd1);
    tick();
    i_redirect_ready = 1'b0;
    #1;
    check("ret_exit_valid", 32'(o_redirect_valid), 32'd0);

    // Reset asserted during ENTER.
    i_instr_done = 1'b1; i_next_pc = 32'h500;
    tick();
    i_instr_done = 1'b0;
    #1;
    check("rstent_in_enter", 32'(o_we_1), 32'd1);
    arstn = 1'b0;
    #1;
    check("rstent_we_1", 32'(o_we_1), 32'd0);
    check("rstent_we_2", 32'(o_we_2), 32'd0);
    check("rstent_jump", 32'(o_interrupt_jump), 32'd0);
    check("rstent_stall", 32'(o_csr_stall), 32'd0);
    check("rstent_raddr", 32'(o_raddr), 32'd0);
    tick(); tick();
    arstn = 1'b1;
    i_csr_we = 1'b1; i_csr_addr = 3'd4; i_csr_wdata = 32'h77;
    #1;
    check("post_rst_we_1", 32'(o_we_1), 32'd1);
    check("post_rst_wdata_1", o_wdata_1, 32'h77);
    check("post_rst_stall", 32'(o_csr_stall), 32'd0);
    tick();
    i_csr_we = 1'b0;
    #1;
    check("post_rst_no_entry", 32'(o_we_2), 32'd0);
    check("post_rst_valid", 32'(o_redirect_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Trap sequencer for the machine-mode CSR file. It detects enabled pending machine interrupts at instruction boundaries and owns the CSR file's two write ports. It sequences interrupt entry (mepc/mcause save, MIE/MPIE update, mtvec redirect) and MRET return (MIE restore, mepc redirect). When idle, it forwards the core's CSR-instruction writes and reads to the CSR file.

## Interface
- `DATA_WIDTH`, 32, CSR and PC width.
- `ADDR_WIDTH`, 3, CSR file address width.
- `clk`  in  1  core clock.
- `arstn`  in  1  asynchronous reset, active low.
- `i_instr_done`  in  1  instruction retires this cycle; this is the interrupt-evaluation boundary.
- `i_next_pc`  in  DATA_WIDTH  PC of the next instruction; valid with `i_instr_done`.
- `i_mret`  in  1  retiring instruction is MRET; single-cycle strobe.
- `i_csr_we`, `i_csr_addr`, `i_csr_wdata`  in  1/ADDR_WIDTH/DATA_WIDTH  CSR-instruction write request.
- `i_csr_raddr`  in  ADDR_WIDTH  CSR-instruction read address.
- `i_mie_mstatus`, `i_mtip_mip`, `i_msip_mip`, `i_mtie_mie`, `i_msie_mie`  in  1 each  status bits from the CSR file.
- `i_csr_rdata`  in  DATA_WIDTH  CSR file read data.
- `i_redirect_ready`  in  1  fetch accepts the redirect.
- `o_we_1`, `o_waddr_1`, `o_wdata_1`, `o_we_2`, `o_waddr_2`, `o_wdata_2`  out  CSR file write ports.
- `o_raddr`  out  ADDR_WIDTH  CSR file read address.
- `o_interrupt_jump`, `o_mret_instr`  out  1  CSR file MIE/MPIE control strobes.
- `o_csr_stall`  out  1  core must hold its CSR request and retire nothing.
- `o_redirect_valid`  out  1  redirect PC is valid.
- `o_redirect_pc`  out  DATA_WIDTH  redirect target PC.

## Operation
- CSR map: mstatus=0, mie=2, mtvec=3, mcause=4, mepc=5, mip=6.
- States: IDLE, DEFER, ENTER, VEC, RET.
- **IDLE**
  - Port 1 mirrors `i_csr_we`/`i_csr_addr`/`i_csr_wdata`.
  - `o_raddr = i_csr_raddr`.
  - `o_csr_stall = 0`.
- **Pending condition.** An interrupt is pending when `i_mie_mstatus & ((i_msip_mip & i_msie_mie) | (i_mtip_mip & i_mtie_mie))`.
- **Priority.** Software interrupt beats timer interrupt.
  - Software interrupt: mcause = 32'h8000_0003.
  - Timer interrupt: mcause = 32'h8000_0007.
- **IDLE transitions**
  - `i_mret`: go to RET. MRET beats any pending interrupt.
  - `i_instr_done & i_csr_we`: latch `i_next_pc`, then go to DEFER. This lets the CSR write commit before evaluation.
  - `i_instr_done` with no CSR write and an interrupt pending: latch the PC and cause, then go to ENTER.
- **DEFER:** stall. Re-evaluate the pending condition using post-write bits.
  - Pending: go to ENTER with the latched PC.
  - Not pending: go to IDLE.
- **ENTER** (exactly one cycle, stalled):
  - `o_we_1=1`, `o_waddr_1=5`, `o_wdata_1` = saved PC.
  - `o_we_2=1`, `o_waddr_2=4`, `o_wdata_2` = cause.
  - `o_interrupt_jump=1`, `o_raddr=3`.
  - Next state: VEC.
- **VEC:** stall, `o_raddr=3`, `o_redirect_valid=1`, `o_redirect_pc` = mtvec target. Go to IDLE on `i_redirect_ready`.
- **RET:**
  - First cycle: `o_mret_instr=1`.
  - Every cycle: `o_raddr=5`, stall, `o_redirect_valid=1`, `o_redirect_pc = i_csr_rdata`.
  - Go to IDLE on `i_redirect_ready`.
- CSR-instruction writes never reach the ports outside IDLE.

## Timing
- Reset: state IDLE; all outputs 0; saved PC and cause registers 0.
- Entry latency: `i_instr_done` → ENTER next cycle → VEC the cycle after.
  - Redirect appears 2 cycles after the boundary.
  - With a coincident CSR write, it appears 3 cycles after.
- `o_redirect_valid` and `o_redirect_pc` are held stable until `i_redirect_ready`; a zero-wait ready returns to IDLE the next cycle.
- Interrupt bits changing in VEC or RET are ignored until the next boundary.
- `arstn` asserted in any state forces IDLE immediately; no partial writes occur after assertion.

## Configuration
- `CSR_TRAP_VECTORED_EN` defined:
  - If mtvec[1:0]==2'b01, target = {mtvec[31:2],2'b00} + 4·cause[3:0] (MSI→+12, MTI→+28).
  - Otherwise target = {mtvec[31:2],2'b00}.
- Undefined: target is always {mtvec[31:2],2'b00}.

## Structure
- Shared package `csr_pkg`:
  - FSM state enum.
  - CSR address constants.
  - mcause constants.
- One sub-module, `csr_int_prio`: combinational pending/priority/cause encoder, used in IDLE and DEFER.

## Test plan
- Interrupt entry:
  - Stimulus: mstatus.MIE=1, mie.MTIE=1, mip.MTIP=1, `i_instr_done` with `i_next_pc`=0x100, mtvec=0x8000_0000.
  - Response: ENTER writes mepc=0x100 and mcause=0x8000_0007, `o_interrupt_jump`=1; redirect 0x8000_0000 two cycles later.
- Priority:
  - Stimulus: MSIP and MTIP both pending and enabled.
  - Response: mcause=0x8000_0003. With vectored mtvec=0x8000_0001, redirect=0x8000_000C (macro on) or 0x8000_0000 (macro off).
- CSR-write coincidence:
  - Stimulus: `i_csr_we` writes mstatus=0 alongside `i_instr_done` with MTIP pending.
  - Response: write committed, DEFER, no entry, IDLE.
- MRET:
  - Stimulus: mepc=0x200, `i_mret` pulse.
  - Response: `o_mret_instr` high 1 cycle, redirect 0x200; MRET taken even while an interrupt is pending.
- Backpressure:
  - Stimulus: `i_redirect_ready` low for 5 cycles in VEC.
  - Response: redirect stable and `o_csr_stall`=1 throughout; IDLE after ready.
- Reset mid-ENTER:
  - Stimulus: `arstn` low during ENTER.
  - Response: all outputs 0 immediately, state IDLE after release.
